div_datapath: RTL and testbench

Datapath for the 16-bit sequential restoring divider. It sits directly downstream of the divider controller and consumes its load/add/shift/inbit/sel/valid strobes. It returns sign, the remainder MSB, which the controller uses to decide whether to restore. Final quotient and remainder are captured into holding registers on valid for the consuming logic.

---
 rtl/div_datapath_pkg.sv | 14 +
 rtl/div_addsub.sv | 32 +++
 rtl/div_datapath.sv | 86 ++++++++
 tb/tb_div_datapath.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/div_datapath_pkg.sv
// Shared definitions for the 16-bit restoring divider: default operand width
// and the adder operand-select encodings used by controller and datapath.
package div_datapath_pkg;

    localparam int DIV_N = 16;

    typedef enum logic [1:0] {
        SEL_SUB  = 2'b00,
        SEL_ADD  = 2'b01,
        SEL_ZERO = 2'b10,
        SEL_RSVD = 2'b11
    } sel_e;

endpackage

// File: rtl/div_addsub.sv
// Combinational remainder adder: R_out = R_in + opnd(sel), evaluated at W+2
// bits with the divisor zero-extended, then truncated back to W+1 bits.
module div_addsub
    import div_datapath_pkg::*;
#(
    parameter int W = DIV_N
) (
    input  logic [W:0]   r_in,
    input  logic [W-1:0] d,
    input  logic [1:0]   sel,
    output logic [W:0]   r_out
);

    logic [W+1:0] opnd;
    logic [W+1:0] sum;
    logic         unused_carry;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        opnd = '0;
        case (sel_e'(sel))
            SEL_SUB: opnd = -{2'b00, d};
            SEL_ADD: opnd = {2'b00, d};
            default: opnd = '0;    // SEL_RSVD deliberately aliases SEL_ZERO
        endcase
        sum = {r_in[W], r_in} + opnd;
    end

    assign r_out        = sum[W:0];
    assign unused_carry = sum[W+1];

endmodule

// File: rtl/div_datapath.sv
// Restoring-divider datapath: R/Q/D registers driven by controller strobes,
// plus holding registers that capture the final quotient and remainder.
module div_datapath
    import div_datapath_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         add,
    input  logic         shift,
    input  logic         inbit,
    input  logic [1:0]   sel,
    input  logic         valid,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         sign,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done
);

    logic [N:0]   r_q, r_d, r_shift, alu_in, alu_out;
    logic [N-1:0] q_q, q_d, d_q, d_d;
    logic [N-1:0] quot_q, quot_d, rem_q, rem_d;
    logic         done_q, done_d;

    // The adder sees the shifted remainder when shift and add coincide.
    assign r_shift = {r_q[N-1:0], q_q[N-1]};
    assign alu_in  = shift ? r_shift : r_q;

    div_addsub #(.W(N)) u_addsub (
        .r_in  (alu_in),
        .d     (d_q),
        .sel   (sel),
        .r_out (alu_out)
    );

    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        d_d    = d_q;
        if (load) begin
            r_d = '0;
            q_d = dividend;
            d_d = divisor;
        end else if (shift) begin
            r_d = add ? alu_out : r_shift;
            q_d = {q_q[N-2:0], inbit};
        end else if (add) begin
            r_d = alu_out;
            q_d = {q_q[N-1:1], inbit};
        end

        // Capture reads the pre-update R/Q, so a coincident strobe does not leak in.
        quot_d = valid ? q_q : quot_q;
        rem_d  = valid ? r_q[N-1:0] : rem_q;
        done_d = valid;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            done_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            d_q    <= d_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            done_q <= done_d;
        end
    end

    assign sign      = r_q[N];
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: tb/tb_div_datapath.sv
// Self-checking bench for div_datapath: an arithmetic reference model checked
// every cycle, directed division scenarios and randomized strobe traffic.
module tb_div_datapath;
    import div_datapath_pkg::*;

    logic        clk = 1'b0;
    logic        reset, load, add, shift, inbit, valid;
    logic [1:0]  sel;
    logic [15:0] dividend, divisor;
    logic        sign, done;
    logic [15:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    div_datapath dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .add       (add),
        .shift     (shift),
        .inbit     (inbit),
        .sel       (sel),
        .valid     (valid),
        .dividend  (dividend),
        .divisor   (divisor),
        .sign      (sign),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: R as a signed integer wrapped into the 17-bit range.
    longint m_r;
    int     m_q, m_d, m_quot, m_rem;
    bit     m_done, m_ok = 1'b0;

    function automatic longint wrapr(input longint x);
        longint m;
        m = x & 64'h1FFFF;
        if (m >= 65536) m -= 131072;
        return m;
    endfunction

    always @(posedge clk) begin
        longint opnd, base;
        if (reset) begin
            m_r = 0; m_q = 0; m_d = 0; m_quot = 0; m_rem = 0; m_done = 0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            if (valid) begin
                m_quot = m_q;
                m_rem  = int'(m_r & 64'hFFFF);
            end
            m_done = valid;
            opnd = (sel == 2'b00) ? -longint'(m_d) : (sel == 2'b01) ? longint'(m_d) : 0;
            if (load) begin
                m_r = 0; m_q = int'(dividend); m_d = int'(divisor);
            end else if (shift) begin
                base = 2 * m_r + ((m_q >> 15) & 1);
                if (add) base += opnd;
                m_r = wrapr(base);
                m_q = ((m_q << 1) | int'(inbit)) & 32'hFFFF;
            end else if (add) begin
                m_r = wrapr(m_r + opnd);
                m_q = (m_q & 32'hFFFE) | int'(inbit);
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("sign", sign, m_r < 0);
            check("quotient", quotient, m_quot);
            check("remainder", remainder, m_rem);
            check("done", done, m_done);
        end
    end

    bit saw_sign;

    task automatic step(input bit rs, input bit ld, input bit ad, input bit sh, input bit ib,
                        input logic [1:0] sl, input bit vl, input logic [15:0] a, input logic [15:0] b);
        reset = rs; load = ld; add = ad; shift = sh; inbit = ib; sel = sl; valid = vl;
        dividend = a; divisor = b;
        @(posedge clk);
        #1;
        if (sign) saw_sign = 1'b1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 2'b00, 0, 16'h0, 16'h0);
    endtask

    task automatic do_div(input logic [15:0] a, input logic [15:0] b, input int abort_at);
        saw_sign = 1'b0;
        step(0, 1, 0, 0, 0, 2'b00, 0, a, b);
        for (int i = 0; i < 16; i++) begin
            if (i == abort_at) return;
            step(0, 0, 1, 1, 1, SEL_SUB, 0, 16'h0, 16'h0);
            if (m_r < 0) step(0, 0, 1, 0, 0, SEL_ADD, 0, 16'h0, 16'h0);
        end
        step(0, 0, 0, 0, 0, 2'b00, 1, 16'h0, 16'h0);
    endtask

    initial begin
        reset = 0; load = 0; add = 0; shift = 0; inbit = 0; sel = 2'b00; valid = 0;
        dividend = 16'h0; divisor = 16'h0;
        @(posedge clk);
        #1;

        // Reset with every strobe high.
        step(1, 1, 1, 1, 1, 2'b00, 1, 16'hFFFF, 16'hFFFF);
        step(1, 1, 1, 1, 1, 2'b00, 1, 16'hFFFF, 16'hFFFF);
        check("rst_sign", sign, 0);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_done", done, 0);
        idle();

        do_div(16'd100, 16'd7, -1);
        check("d100_7_q", quotient, 14);
        check("d100_7_r", remainder, 2);
        check("d100_7_done", done, 1);
        idle();
        check("d100_7_done_low", done, 0);

        do_div(16'hFFFF, 16'd1, -1);
        check("dffff_1_q", quotient, 16'hFFFF);
        check("dffff_1_r", remainder, 0);

        do_div(16'h1234, 16'd0, -1);
        check("div0_q", quotient, 16'hFFFF);
        check("div0_r", remainder, 16'h1234);
        check("div0_no_sign", saw_sign, 0);

        // Strobe precedence: load beats shift/add; sel 10/11 add nothing.
        step(0, 1, 1, 1, 1, SEL_SUB, 0, 16'hABCC, 16'd5);
        step(0, 0, 0, 0, 0, 2'b00, 1, 16'h0, 16'h0);
        check("prec_load_q", quotient, 16'hABCC);
        check("prec_load_r", remainder, 0);
        step(0, 0, 0, 1, 0, 2'b00, 0, 16'h0, 16'h0);
        step(0, 0, 1, 0, 1, SEL_ZERO, 0, 16'h0, 16'h0);
        step(0, 0, 0, 0, 0, 2'b00, 1, 16'h0, 16'h0);
        check("sel10_q", quotient, 16'h5799);
        check("sel10_r", remainder, 1);
        step(0, 0, 1, 0, 0, SEL_RSVD, 1, 16'h0, 16'h0);
        step(0, 0, 0, 0, 0, 2'b00, 1, 16'h0, 16'h0);
        check("sel11_q", quotient, 16'h5798);
        check("sel11_r", remainder, 1);
        check("valid_back2back_done", done, 1);
        idle();
        check("valid_back2back_done_low", done, 0);

        // Abort mid-division with reset, then a clean division.
        do_div(16'd1000, 16'd3, 8);
        step(1, 0, 0, 0, 0, 2'b00, 0, 16'h0, 16'h0);
        idle();
        check("abort_done", done, 0);
        check("abort_quot", quotient, 0);
        do_div(16'd200, 16'd13, -1);
        check("d200_13_q", quotient, 15);
        check("d200_13_r", remainder, 5);

        // Load mid-division restarts without touching captured outputs.
        do_div(16'd999, 16'd10, 5);
        check("restart_hold_q", quotient, 15);
        do_div(16'd999, 16'd10, -1);
        check("restart_q", quotient, 99);
        check("restart_r", remainder, 9);

        // Random divisions against plain integer division.
        for (int k = 0; k < 30; k++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = (k % 5 == 0) ? 16'h0 : 16'($urandom_range(1, (k % 2) ? 65535 : 300));
            do_div(a, b, -1);
            check("rand_q", quotient, (b == 0) ? 16'hFFFF : a / b);
            check("rand_r", remainder, (b == 0) ? a : a % b);
        end

        // Random strobe traffic, checked by the per-cycle compare.
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
                 1'($urandom), 1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
                 16'($urandom), 16'($urandom));
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
